// File: rtl/mips_ctrl_fsm.sv
// Multicycle Moore control sequencer for the byte-fetch MIPS datapath.
// Optional feature: define MIPS_CTRL_ADDI_EN to decode ADDI (states ADDIEX/ADDIWR).
module mips_ctrl_fsm (
    input  logic        clk_i_top,
    input  logic        rst_i_top,
    input  logic [31:0] instr,
    output logic        fetch_en,
    output logic        IorD,
    output logic        MemWrite,
    output logic [3:0]  IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        Branch,
    output logic        PCWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic [3:0]  state_o,
    output logic        illegal_op_o
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,  FETCH2  = 4'd1,  FETCH3  = 4'd2,  FETCH4 = 4'd3,
        DECODE  = 4'd4,  MEMADR  = 4'd5,  LBRD    = 4'd6,  LBWR   = 4'd7,
        SBWR    = 4'd8,  RTYPEEX = 4'd9,  RTYPEWR = 4'd10, BEQEX  = 4'd11,
        JEX     = 4'd12, ADDIEX  = 4'd13, ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_q, state_d;
    logic [5:0] opcode;
    logic       decode_illegal;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign unused_instr_bits = ^instr[25:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i_top) begin
        if (rst_i_top) state_q <= FETCH1;
        else           state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case, so no latch is inferred.
    always_comb begin
        state_d        = FETCH1;
        decode_illegal = 1'b0;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = FETCH3;
            FETCH3: state_d = FETCH4;
            FETCH4: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default: begin
                        state_d        = FETCH1;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LB)      state_d = LBRD;
                else if (opcode == OP_SB) state_d = SBWR;
                else                      state_d = FETCH1;
            end
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
`ifdef MIPS_CTRL_ADDI_EN
            ADDIEX:  state_d = ADDIWR;
`endif
            default: state_d = FETCH1;
        endcase
    end

    // Moore outputs; reset overrides everything so no strobe fires while held.
    always_comb begin
        fetch_en     = 1'b0;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 4'b0000;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSrc        = 2'b00;
        Branch       = 1'b0;
        PCWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        state_o      = 4'd0;
        illegal_op_o = 1'b0;
        if (!rst_i_top) begin
            state_o = state_q;
            case (state_q)
                FETCH1, FETCH2, FETCH3, FETCH4: begin
                    fetch_en = 1'b1;
                    IRWrite  = 4'b0001 << state_q[1:0];
                    ALUSrcB  = 2'b01;
                    PCWrite  = 1'b1;
                end
                DECODE: begin
                    ALUSrcB      = 2'b11;
                    illegal_op_o = decode_illegal;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                LBRD: IorD = 1'b1;
                LBWR: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                SBWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                RTYPEEX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                RTYPEWR: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BEQEX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                    PCSrc   = 2'b01;
                end
                JEX: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
`ifdef MIPS_CTRL_ADDI_EN
                ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ADDIWR: RegWrite = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Self-checking bench for mips_ctrl_fsm: directed and random instructions against
// an instruction-level model (state path per opcode plus per-state output table).
module tb_mips_ctrl_fsm;

    typedef struct packed {
        logic       fetch_en;
        logic       IorD;
        logic       MemWrite;
        logic [3:0] IRWrite;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSrc;
        logic       Branch;
        logic       PCWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic [3:0] state;
        logic       illegal;
    } outs_t;

    logic        clk_i_top = 1'b0;
    logic        rst_i_top = 1'b1;
    logic [31:0] instr     = 32'hFFFF_FFFF;
    logic        fetch_en, IorD, MemWrite, RegWrite, ALUSrcA, Branch, PCWrite, RegDst, MemtoReg;
    logic [3:0]  IRWrite, state_o;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic        illegal_op_o;

    int checks   = 0;
    int failures = 0;

    mips_ctrl_fsm dut (
        .clk_i_top(clk_i_top), .rst_i_top(rst_i_top), .instr(instr),
        .fetch_en(fetch_en), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .Branch(Branch), .PCWrite(PCWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .state_o(state_o), .illegal_op_o(illegal_op_o)
    );

    always #5 clk_i_top = ~clk_i_top;

    function automatic outs_t observed();
        outs_t o;
        o = {fetch_en, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSrc, Branch, PCWrite, RegDst, MemtoReg, state_o, illegal_op_o};
        return o;
    endfunction

    function automatic bit is_legal(logic [5:0] op);
`ifdef MIPS_CTRL_ADDI_EN
        return op inside {6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000};
`else
        return op inside {6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010};
`endif
    endfunction

    // State path of one instruction from FETCH1 up to (not including) the return to FETCH1.
    function automatic void build_path(logic [5:0] op, ref int q[$]);
        q = '{0, 1, 2, 3, 4};
        case (op)
            6'b100000: q = {q, 5, 6, 7};
            6'b101000: q = {q, 5, 8};
            6'b000000: q = {q, 9, 10};
            6'b000100: q.push_back(11);
            6'b000010: q.push_back(12);
`ifdef MIPS_CTRL_ADDI_EN
            6'b001000: q = {q, 13, 14};
`endif
            default: ;
        endcase
    endfunction

    // Output table written from the per-state description of the datapath controls.
    function automatic outs_t expected(int st, bit ill);
        outs_t e;
        e = '0;
        e.state = st[3:0];
        case (st)
            0, 1, 2, 3: begin
                e.fetch_en = 1; e.IRWrite = 4'(1 << st); e.ALUSrcB = 2'b01; e.PCWrite = 1;
            end
            4:  begin e.ALUSrcB = 2'b11; e.illegal = ill; end
            5:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            6:  e.IorD = 1;
            7:  begin e.RegWrite = 1; e.MemtoReg = 1; end
            8:  begin e.IorD = 1; e.MemWrite = 1; end
            9:  begin e.ALUSrcA = 1; e.ALUOp = 2'b10; end
            10: begin e.RegWrite = 1; e.RegDst = 1; end
            11: begin e.ALUSrcA = 1; e.ALUOp = 2'b01; e.Branch = 1; e.PCSrc = 2'b01; end
            12: begin e.PCWrite = 1; e.PCSrc = 2'b10; end
            13: begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            14: e.RegWrite = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Opcode must be present only in DECODE/MEMADR; elsewhere instr is pure noise.
    task automatic drive_instr(int st, logic [5:0] op);
        logic [31:0] r;
        r = $urandom;
        instr = (st == 4 || st == 5) ? {op, r[25:0]} : r;
    endtask

    task automatic test_reset();
        outs_t got;
        rst_i_top = 1'b1;
        instr     = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i_top); #1;
            got = observed();
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: got %h want 0", i, got);
            end
        end
        rst_i_top = 1'b0;
        #3;
        got = observed();
        checks++;
        if (got !== expected(0, 0)) begin
            failures++;
            $display("FAIL reset_release: got %h want %h", got, expected(0, 0));
        end
        @(posedge clk_i_top); #1;
        // Realign: next instruction starts at FETCH1, so redo the reset for a clean start.
        rst_i_top = 1'b1;
        @(posedge clk_i_top); #1;
        rst_i_top = 1'b0;
    endtask

    // Runs one instruction starting in FETCH1, checking every cycle and the latency.
    task automatic run_instr(string name, logic [5:0] op);
        int    q[$];
        outs_t got, exp_o;
        build_path(op, q);
        foreach (q[i]) begin
            drive_instr(q[i], op);
            #3;
            got   = observed();
            exp_o = expected(q[i], q[i] == 4 && !is_legal(op));
            checks++;
            if (got !== exp_o) begin
                failures++;
                $display("FAIL %s cyc%0d: got %h want %h", name, i, got, exp_o);
            end
            @(posedge clk_i_top); #1;
        end
        checks++;
        if (state_o !== 4'd0) begin
            failures++;
            $display("FAIL %s latency%0d: state_o got %0d want 0", name, q.size(), state_o);
        end
    endtask

    task automatic test_directed();
        logic [31:0] w;
        w = 32'h8001_0004; run_instr("lb",      w[31:26]);
        w = 32'h0022_1820; run_instr("rtype",   w[31:26]);
        w = 32'h1022_0003; run_instr("beq",     w[31:26]);
        w = 32'hFC00_0000; run_instr("illegal", w[31:26]);
        w = 32'h2001_0005; run_instr("addi",    w[31:26]);
        w = 32'hA001_0000; run_instr("sb",      w[31:26]);
        w = 32'h0800_0010; run_instr("j",       w[31:26]);
    endtask

    // Asserts reset during path step stop_idx; no strobe that cycle, FETCH1 afterwards.
    task automatic test_reset_mid(string name, logic [5:0] op, int stop_idx);
        int    q[$];
        outs_t got;
        build_path(op, q);
        for (int i = 0; i < stop_idx; i++) begin
            drive_instr(q[i], op);
            @(posedge clk_i_top); #1;
        end
        drive_instr(q[stop_idx], op);
        rst_i_top = 1'b1;
        #3;
        got = observed();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL %s in-reset st%0d: got %h want 0", name, q[stop_idx], got);
        end
        @(posedge clk_i_top); #1;
        rst_i_top = 1'b0;
        #3;
        got = observed();
        checks++;
        if (got !== expected(0, 0)) begin
            failures++;
            $display("FAIL %s after-reset: got %h want %h", name, got, expected(0, 0));
        end
        @(posedge clk_i_top); #1;
        rst_i_top = 1'b1;
        @(posedge clk_i_top); #1;
        rst_i_top = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] ops[8];
        logic [5:0] op;
        int         q[$];
        ops = '{6'b000000, 6'b100000, 6'b101000, 6'b000100,
                6'b000010, 6'b001000, 6'b111111, 6'b000000};
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (n % 7 == 6) op = 6'($urandom);
            run_instr("rand", op);
        end
        for (int n = 0; n < 10; n++) begin
            op = ops[$urandom_range(0, 6)];
            build_path(op, q);
            test_reset_mid("rand_rst", op, $urandom_range(0, q.size() - 1));
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        op = 6'b101000;
        test_reset_mid("sb_rst_in_sbwr", op, 6);
        op = 6'b100000;
        test_reset_mid("lb_rst_in_lbwr", op, 7);
        run_instr("lb_after_rst", op);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
